outlier_lane_scheduler: RTL and testbench
=========================================

Name: outlier_lane_scheduler

Overview:
- Sequences the outlier multiply path. Accepts one DIMM-wide overflow mask per job.
- Drains the set bits onto NUM_LR FP-multiplier lanes, lowest index first, NUM_LR per beat.
- Provides per-lane index/enable, per-beat valid/ready handshake and a job-done pulse.
- Replaces the fixed single-shot leftmost selection: any number of outliers (0..DIMM) is serviced over ceil(count/NUM_LR) beats.

Parameters:
- DIMM, 64, width of overflow mask / vector dimension.
- NUM_LR, 4, number of multiplier lanes issued per beat (1 <= NUM_LR <= DIMM).
- INDEX_WIDTH, $clog2(DIMM), width of one element index.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  new overflow mask offered.
- in_ready  output  1  scheduler can accept a mask; high only in IDLE.
- overflow  input  DIMM  outlier mask; bit i set = element i is an outlier.
- issue_valid  output  1  lane_index/lane_en hold a valid beat.
- issue_ready  input  1  multiplier stage accepts the beat.
- lane_en  output  NUM_LR  per-lane valid within the beat.
- lane_index  output  NUM_LR x INDEX_WIDTH  element index per lane.
- issue_last  output  1  current beat is the final beat of the job.
- done  output  1  one-cycle pulse at job completion.
- outlier_count  output  INDEX_WIDTH+1  popcount of the last accepted mask.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, pending mask = 0, outlier_count = 0.
  - issue_valid, lane_en, lane_index, issue_last and done are all 0.
  - in_ready = 1.
- State register: IDLE, ISSUE, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture overflow into pending and popcount(overflow) into outlier_count.
  - Next state is ISSUE if the mask is nonzero, else DONE. A zero mask produces no beats.
- ISSUE:
  - in_ready = 0. issue_valid = 1. in_valid is ignored.
  - Lane k (k = 0..NUM_LR-1) gets the (k+1)-th lowest set bit of pending. lane_en[k] = 1 when that bit exists.
  - Lanes with no bit: lane_en = 0, lane_index = 0.
  - Enabled lanes always form a contiguous low group (lane_en has the form 0..01..1).
  - issue_last = 1 when popcount(pending) <= NUM_LR.
  - lane_index, lane_en and issue_last are combinational from the registered pending mask. They must hold stable while issue_valid && !issue_ready, i.e. unbounded backpressure.
  - On issue_valid && issue_ready: clear every issued bit in pending. If issue_last, go to DONE; otherwise stay in ISSUE.
- DONE:
  - done = 1 for exactly one cycle, then return to IDLE.
  - outlier_count is valid from the cycle after acceptance and holds until the next acceptance.
- Latency and throughput:
  - First beat is presented the cycle after acceptance.
  - With issue_ready tied high, a job of C outliers (C > 0) takes ceil(C/NUM_LR) beats on consecutive cycles, plus a DONE cycle.
  - A zero-outlier job takes 1 cycle (DONE), then IDLE.
  - Minimum accept-to-accept spacing = beats + 2 cycles.
- Boundary cases:
  - Full mask: DIMM/NUM_LR beats, in ascending index order.
  - Popcount an exact multiple of NUM_LR: last beat has all lanes enabled.
  - Single bit at index DIMM-1: one beat, lane 0 = DIMM-1, lane_en = 0...01.
- Reset mid-job: all state is discarded, outputs return to reset values immediately, no done pulse is produced.
- Selection: implement as NUM_LR cascaded find-first-set stages, each masking the bits found by earlier stages. A single-cycle combinational path is required; no extra pipeline stage.

Test Plan:
- Reset check: assert rst_n = 0 mid-run.
  - Required: issue_valid = 0, done = 0, lane_en = 0, outlier_count = 0, in_ready = 1 asynchronously.
  - Required: no activity after release until in_valid.
- Zero mask: overflow = 0, in_valid for 1 cycle.
  - Required: no issue_valid; done pulses the next cycle; outlier_count = 0; in_ready high again one cycle later.
- Partial beat: bits {5,17,40} set, issue_ready = 1.
  - Required: one beat with lane_index = {5,17,40,0}, lane_en = 0111, issue_last = 1.
  - Required: done the next cycle, outlier_count = 3.
- Full mask: all 64 bits set, issue_ready = 1.
  - Required: 16 consecutive beats; beat k has indices 4k..4k+3 and lane_en = 1111; issue_last only on beat 15.
  - Required: outlier_count = 64.
- Backpressure: bits {1,2,3,4,9} set, issue_ready low for 3 cycles then high.
  - Required: beat 1 = {1,2,3,4} held stable for 4 cycles; beat 2 = {9}, lane_en = 0001, issue_last = 1.
  - Required: in_valid pulses during ISSUE are not accepted and do not change outlier_count.
- Reset mid-job: all-ones mask, assert rst_n after 5 beats.
  - Required: no done pulse.
  - Required: a new mask {63} then yields a single beat with lane 0 = 63 and outlier_count = 1.

Source files
------------

// File: rtl/outlier_lane_scheduler.sv
// Drains a per-job outlier mask onto NUM_LR multiplier lanes, lowest index first,
// one beat per accepted issue handshake, followed by a one-cycle done pulse.
module outlier_lane_scheduler #(
  parameter int unsigned DIMM        = 64,
  parameter int unsigned NUM_LR      = 4,
  parameter int unsigned INDEX_WIDTH = $clog2(DIMM)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DIMM-1:0]                       overflow,
  output logic                                  issue_valid,
  input  logic                                  issue_ready,
  output logic [NUM_LR-1:0]                     lane_en,
  output logic [NUM_LR-1:0][INDEX_WIDTH-1:0]    lane_index,
  output logic                                  issue_last,
  output logic                                  done,
  output logic [INDEX_WIDTH:0]                  outlier_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e                 state_q, state_d;
  logic [DIMM-1:0]        pending_q, pending_d;
  logic [INDEX_WIDTH:0]   count_q, count_d;

  logic [DIMM-1:0]                 remain [NUM_LR+1];
  logic [NUM_LR-1:0]               en_raw;
  logic [NUM_LR-1:0][INDEX_WIDTH-1:0] idx_raw;
  logic                            last_raw;

  function automatic logic [INDEX_WIDTH-1:0] lowest_set(input logic [DIMM-1:0] v);
    logic [INDEX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = int'(DIMM) - 1; i >= 0; i--) begin
      if (v[i]) idx = INDEX_WIDTH'(i);
    end
    return idx;
  endfunction

  function automatic logic [INDEX_WIDTH:0] popcount(input logic [DIMM-1:0] v);
    logic [INDEX_WIDTH:0] sum;
    sum = '0;
    for (int i = 0; i < int'(DIMM); i++) begin
      sum = sum + {{INDEX_WIDTH{1'b0}}, v[i]};
    end
    return sum;
  endfunction

  // Cascaded find-first-set: each stage strips the lowest bit the previous one found.
  always_comb begin
    remain[0] = pending_q;
    en_raw    = '0;
    idx_raw   = '0;
    for (int k = 0; k < int'(NUM_LR); k++) begin
      en_raw[k]     = |remain[k];
      idx_raw[k]    = en_raw[k] ? lowest_set(remain[k]) : '0;
      remain[k + 1] = remain[k] & (remain[k] - DIMM'(1));
    end
    // Nothing left after this beat means popcount(pending) <= NUM_LR.
    last_raw = ~|remain[NUM_LR];
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    count_d     = count_q;
    in_ready    = 1'b0;
    issue_valid = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pending_d = overflow;
          count_d   = popcount(overflow);
          state_d   = (|overflow) ? StIssue : StDone;
        end
      end
      StIssue: begin
        issue_valid = 1'b1;
        if (issue_ready) begin
          pending_d = remain[NUM_LR];
          if (last_raw) state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign lane_en       = issue_valid ? en_raw  : '0;
  assign lane_index    = issue_valid ? idx_raw : '0;
  assign issue_last    = issue_valid & last_raw;
  assign outlier_count = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_outlier_lane_scheduler.sv
// Directed-vector bench for outlier_lane_scheduler with DIMM=64, NUM_LR=4.
module tb_outlier_lane_scheduler;

  localparam int unsigned DIMM   = 64;
  localparam int unsigned NUM_LR = 4;
  localparam int unsigned IW     = 6;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          in_valid;
  logic                          in_ready;
  logic [DIMM-1:0]               overflow;
  logic                          issue_valid;
  logic                          issue_ready;
  logic [NUM_LR-1:0]             lane_en;
  logic [NUM_LR-1:0][IW-1:0]     lane_index;
  logic                          issue_last;
  logic                          done;
  logic [IW:0]                   outlier_count;

  int n_vec  = 0;
  int n_miss = 0;

  outlier_lane_scheduler #(
    .DIMM       (DIMM),
    .NUM_LR     (NUM_LR),
    .INDEX_WIDTH(IW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .overflow     (overflow),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .lane_en      (lane_en),
    .lane_index   (lane_index),
    .issue_last   (issue_last),
    .done         (done),
    .outlier_count(outlier_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DIMM-1:0] m;

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    overflow    = '0;
    issue_ready = 1'b1;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lane_en", 64'(lane_en), 64'd0);
    check("rst_count", 64'(outlier_count), 64'd0);
    rst_n = 1'b1;
    step();
    step();
    check("idle_quiet_valid", 64'(issue_valid), 64'd0);
    check("idle_quiet_done", 64'(done), 64'd0);
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // Zero mask
    in_valid = 1'b1;
    overflow = '0;
    step();
    in_valid = 1'b0;
    check("zero_no_issue", 64'(issue_valid), 64'd0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_count", 64'(outlier_count), 64'd0);
    check("zero_busy", 64'(in_ready), 64'd0);
    step();
    check("zero_ready_again", 64'(in_ready), 64'd1);
    check("zero_done_once", 64'(done), 64'd0);

    // Partial beat {5,17,40}
    m = '0;
    m[5] = 1'b1; m[17] = 1'b1; m[40] = 1'b1;
    overflow = m;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("part_valid", 64'(issue_valid), 64'd1);
    check("part_index", 64'(lane_index), 64'(pack4(5, 17, 40, 0)));
    check("part_en", 64'(lane_en), 64'h7);
    check("part_last", 64'(issue_last), 64'd1);
    check("part_count", 64'(outlier_count), 64'd3);
    step();
    check("part_done", 64'(done), 64'd1);
    check("part_no_valid", 64'(issue_valid), 64'd0);
    step();

    // Full mask
    overflow = '1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("full_valid", 64'(issue_valid), 64'd1);
      check("full_index", 64'(lane_index), 64'(pack4(4*k, 4*k+1, 4*k+2, 4*k+3)));
      check("full_en", 64'(lane_en), 64'hf);
      check("full_last", 64'(issue_last), (k == 15) ? 64'd1 : 64'd0);
      check("full_no_done", 64'(done), 64'd0);
      step();
    end
    check("full_done", 64'(done), 64'd1);
    check("full_count", 64'(outlier_count), 64'd64);
    step();

    // Backpressure {1,2,3,4,9}
    m = '0;
    m[1] = 1'b1; m[2] = 1'b1; m[3] = 1'b1; m[4] = 1'b1; m[9] = 1'b1;
    overflow    = m;
    in_valid    = 1'b1;
    issue_ready = 1'b0;
    step();
    overflow = '1;  // offered during ISSUE, must be ignored
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        issue_ready = 1'b1;
        in_valid    = 1'b0;
      end
      check("bp_hold_valid", 64'(issue_valid), 64'd1);
      check("bp_hold_index", 64'(lane_index), 64'(pack4(1, 2, 3, 4)));
      check("bp_hold_en", 64'(lane_en), 64'hf);
      check("bp_hold_last", 64'(issue_last), 64'd0);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      step();
    end
    check("bp_b2_index", 64'(lane_index), 64'(pack4(9, 0, 0, 0)));
    check("bp_b2_en", 64'(lane_en), 64'h1);
    check("bp_b2_last", 64'(issue_last), 64'd1);
    check("bp_count", 64'(outlier_count), 64'd5);
    step();
    check("bp_done", 64'(done), 64'd1);
    check("bp_count_hold", 64'(outlier_count), 64'd5);
    step();

    // Reset mid-job
    overflow = '1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int b = 0; b < 5; b++) step();
    check("mid_beat5_index", 64'(lane_index), 64'(pack4(20, 21, 22, 23)));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(issue_valid), 64'd0);
    check("mid_rst_en", 64'(lane_en), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_count", 64'(outlier_count), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("mid_no_done", 64'(done), 64'd0);
      check("mid_no_valid", 64'(issue_valid), 64'd0);
    end
    m = '0;
    m[63] = 1'b1;
    overflow = m;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("top_index", 64'(lane_index), 64'(pack4(63, 0, 0, 0)));
    check("top_en", 64'(lane_en), 64'h1);
    check("top_last", 64'(issue_last), 64'd1);
    check("top_count", 64'(outlier_count), 64'd1);
    step();
    check("top_done", 64'(done), 64'd1);
    step();
    check("top_idle", 64'(in_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
